// File: rtl/mxregs_ctx.sv
// MX register file with generalised load decoder, primary/shadow bank swap
// and a LIFO context stack that saves/restores the whole file one word per
// cycle. All registers are exposed in parallel on reg_line.
module mxregs_ctx #(
  parameter int WORD_LENGTH = 8,
  parameter int DEPTH       = 16,
  parameter int FLAGS_IDX   = 7,
  parameter int SHADOW_BASE = 8,
  parameter int SWAP_N      = 4,
  parameter int CTX_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DEPTH*WORD_LENGTH-1:0]       data_line,
  input  logic [7:0]                         load_addr,
  input  logic                               load_en,
  input  logic                               swap_req,
  input  logic                               push_req,
  input  logic                               pop_req,
  output logic [DEPTH*WORD_LENGTH-1:0]       reg_line,
  output logic                               busy,
  output logic [$clog2(CTX_DEPTH+1)-1:0]     ctx_level,
  output logic                               ctx_full,
  output logic                               ctx_empty,
  output logic                               ctx_err
);

  localparam int LW = $clog2(CTX_DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;
  localparam logic [3:0] LAST   = 4'(DEPTH - 1);
  localparam logic [7:0] DEPTH8 = 8'(DEPTH);
  localparam logic [4:0] DEPTH5 = 5'(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(CTX_DEPTH);

  typedef enum logic [1:0] {IDLE, PUSH, POP} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  logic [WORD_LENGTH-1:0] regs [DEPTH];
  logic [WORD_LENGTH-1:0] mem  [CTX_DEPTH][DEPTH];

  logic             do_swap;
  logic             set_err;
  logic [DEPTH-1:0] ld_we;
  logic [AW-1:0]    cnt_a;
  logic [IW-1:0]    wr_idx;
  logic [IW-1:0]    rd_idx;
  logic             conflict;

  assign cnt_a     = AW'(cnt);
  // Push writes the next free entry, pop reads the topmost used entry.
  assign wr_idx    = IW'(ctx_level);
  assign rd_idx    = IW'(ctx_level - 1'b1);
  assign busy      = (state != IDLE);
  assign ctx_full  = (ctx_level == FULL_LVL);
  assign ctx_empty = (ctx_level == '0);
  assign conflict  = (push_req && pop_req) || (swap_req && (push_req || pop_req));

  // Expose every register in parallel.
  always_comb begin
    reg_line = '0;
    for (int i = 0; i < DEPTH; i++) reg_line[i*WORD_LENGTH +: WORD_LENGTH] = regs[i];
  end

  // Next-state and request decode; requests are only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    do_swap   = 1'b0;
    set_err   = 1'b0;
    ld_we     = '0;
    case (state)
      IDLE: begin
        if (conflict) begin
          set_err = 1'b1;
        end else if (push_req) begin
          if (ctx_full) set_err = 1'b1;
          else          state_nxt = PUSH;
        end else if (pop_req) begin
          if (ctx_empty) set_err = 1'b1;
          else           state_nxt = POP;
        end else if (swap_req) begin
          do_swap = 1'b1;
        end else if (load_en) begin
          if (load_addr < DEPTH8) begin
            ld_we[load_addr[AW-1:0]] = 1'b1;
          end else if (load_addr[7:4] == 4'h4 && {1'b0, load_addr[3:0]} < DEPTH5) begin
            // Paired load: target register plus FLAGS, each from its own slot.
            ld_we[load_addr[AW-1:0]] = 1'b1;
            ld_we[FLAGS_IDX]         = 1'b1;
          end
        end
      end
      PUSH: if (cnt == LAST) state_nxt = IDLE;
      POP:  if (cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Word index, stack level and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      ctx_level <= '0;
      ctx_err   <= 1'b0;
    end else begin
      if (set_err) ctx_err <= 1'b1;
      case (state)
        PUSH: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt       <= '0;
            ctx_level <= ctx_level + 1'b1;
          end
        end
        POP: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt       <= '0;
            ctx_level <= ctx_level - 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Register file: restore, swap or load; reset clears even a partial restore.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == POP) begin
      regs[cnt_a] <= mem[rd_idx][cnt_a];
    end else if (do_swap) begin
      for (int i = 0; i < SWAP_N; i++) begin
        regs[i]             <= regs[SHADOW_BASE+i];
        regs[SHADOW_BASE+i] <= regs[i];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (ld_we[i]) regs[i] <= data_line[i*WORD_LENGTH +: WORD_LENGTH];
    end
  end

  // Context memory: one word saved per PUSH cycle; contents need no reset.
  always_ff @(posedge clk) begin
    if (state == PUSH) mem[wr_idx][cnt_a] <= regs[cnt_a];
  end

endmodule

// File: tb/tb_mxregs_ctx.sv
// Bench for mxregs_ctx: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the register file and stack.
module tb_mxregs_ctx;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int FI = 7;
  localparam int SB = 8;
  localparam int SN = 4;
  localparam int CD = 4;
  localparam int LW = $clog2(CD + 1);
  localparam int VW = D * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] data_line;
  logic [7:0]    load_addr;
  logic          load_en, swap_req, push_req, pop_req;
  logic [VW-1:0] reg_line;
  logic          busy, ctx_full, ctx_empty, ctx_err;
  logic [LW-1:0] ctx_level;

  mxregs_ctx #(.WORD_LENGTH(W), .DEPTH(D), .FLAGS_IDX(FI), .SHADOW_BASE(SB),
               .SWAP_N(SN), .CTX_DEPTH(CD)) dut (
    .clk(clk), .rst(rst), .data_line(data_line), .load_addr(load_addr),
    .load_en(load_en), .swap_req(swap_req), .push_req(push_req), .pop_req(pop_req),
    .reg_line(reg_line), .busy(busy), .ctx_level(ctx_level), .ctx_full(ctx_full),
    .ctx_empty(ctx_empty), .ctx_err(ctx_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: register array, stack of saved files, remaining busy cycles.
  logic [W-1:0] m_reg  [D];
  logic [W-1:0] m_snap [D];
  logic [W-1:0] m_stk  [CD][D];
  int           m_lvl, m_rem, m_idx;
  bit           m_pop, m_err;

  function automatic logic [W-1:0] slot(input logic [VW-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  task automatic step(input bit r, input bit ld, input logic [7:0] a, input logic [VW-1:0] d,
                      input bit sw, input bit pu, input bit po);
    logic [W-1:0]  t;
    logic [VW-1:0] expv;
    int            k;
    @(negedge clk);
    rst = r; load_en = ld; load_addr = a; data_line = d;
    swap_req = sw; push_req = pu; pop_req = po;
    if (r) begin
      for (int i = 0; i < D; i++) m_reg[i] = '0;
      m_lvl = 0; m_rem = 0; m_err = 0; m_idx = 0;
    end else if (m_rem > 0) begin
      if (m_pop) m_reg[m_idx] = m_stk[m_lvl-1][m_idx];
      m_idx++; m_rem--;
      if (m_rem == 0) begin
        if (m_pop) m_lvl--;
        else begin
          for (int i = 0; i < D; i++) m_stk[m_lvl][i] = m_snap[i];
          m_lvl++;
        end
      end
    end else if ((pu && po) || (sw && (pu || po))) begin
      m_err = 1;
    end else if (pu) begin
      if (m_lvl == CD) m_err = 1;
      else begin
        for (int i = 0; i < D; i++) m_snap[i] = m_reg[i];
        m_pop = 0; m_rem = D; m_idx = 0;
      end
    end else if (po) begin
      if (m_lvl == 0) m_err = 1;
      else begin m_pop = 1; m_rem = D; m_idx = 0; end
    end else if (sw) begin
      for (int i = 0; i < SN; i++) begin
        t = m_reg[i]; m_reg[i] = m_reg[SB+i]; m_reg[SB+i] = t;
      end
    end else if (ld) begin
      if (int'(a) < D) m_reg[a] = slot(d, int'(a));
      else if (int'(a) >= 'h40 && int'(a) < 'h40 + D) begin
        k = int'(a) - 'h40;
        m_reg[k]  = slot(d, k);
        m_reg[FI] = slot(d, FI);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < D; i++) expv[i*W +: W] = m_reg[i];
    chk("regs",  reg_line, expv);
    chk("busy",  VW'(busy), VW'(m_rem > 0));
    chk("level", VW'(ctx_level), VW'(m_lvl));
    chk("full",  VW'(ctx_full), VW'(m_lvl == CD));
    chk("empty", VW'(ctx_empty), VW'(m_lvl == 0));
    chk("err",   VW'(ctx_err), VW'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, '0, 0, 0, 0);
  endtask

  task automatic load(input logic [7:0] a, input logic [W-1:0] v);
    logic [VW-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[(int'(a) % D)*W +: W] = v;
    step(0, 1, a, d, 0, 0, 0);
  endtask

  initial begin
    logic [VW-1:0] d;
    logic [VW-1:0] seq;
    int            bcnt;
    logic [7:0]    a;
    rst = 1; load_en = 0; load_addr = '0; data_line = '0;
    swap_req = 0; push_req = 0; pop_req = 0;
    m_lvl = 0; m_rem = 0; m_err = 0; m_idx = 0; m_pop = 0;
    for (int i = 0; i < D; i++) m_reg[i] = '0;

    step(1, 0, 8'h00, '0, 0, 0, 0);
    step(1, 0, 8'h00, '0, 0, 0, 0);

    // Single load into register 3.
    load(8'h03, 8'hA5);
    chk("t1_reg3", VW'(reg_line[3*W +: W]), VW'(8'hA5));

    // Paired load of register 1 and FLAGS, then an undecoded code.
    d = '0; d[1*W +: W] = 8'h11; d[FI*W +: W] = 8'h80;
    step(0, 1, 8'h41, d, 0, 0, 0);
    chk("t2_reg1", VW'(reg_line[1*W +: W]), VW'(8'h11));
    chk("t2_flags", VW'(reg_line[FI*W +: W]), VW'(8'h80));
    step(0, 1, 8'h16, {VW{1'b1}}, 0, 0, 0);

    // Bank swap with a competing load.
    for (int i = 0; i < 4; i++) load(8'(i), 8'(i + 1));
    for (int i = 8; i < 12; i++) load(8'(i), 8'(i + 1));
    step(0, 1, 8'h00, {VW{1'b1}}, 1, 0, 0);
    chk("t3_reg0", VW'(reg_line[0 +: W]), VW'(8'd9));
    chk("t3_reg8", VW'(reg_line[8*W +: W]), VW'(8'd1));

    // Push a known file, clobber it, pop it back; count busy cycles.
    for (int i = 0; i < D; i++) begin
      load(8'(i), 8'(i));
      seq[i*W +: W] = 8'(i);
    end
    step(0, 0, 8'h00, '0, 0, 1, 0);
    bcnt = 0;
    while (busy && bcnt < 40) begin bcnt++; idle(1); end
    chk("t4_busy_cycles", VW'(bcnt), VW'(D));
    chk("t4_level", VW'(ctx_level), VW'(1));
    for (int i = 0; i < D; i++) load(8'(i), 8'hFF);
    step(0, 0, 8'h00, '0, 0, 0, 1);
    idle(D);
    chk("t4_restored", reg_line, seq);
    chk("t4_empty", VW'(ctx_empty), VW'(1));

    // Fill the stack, then overflow.
    for (int p = 0; p < CD; p++) begin step(0, 0, 8'h00, '0, 0, 1, 0); idle(D); end
    chk("t5_full", VW'(ctx_full), VW'(1));
    step(0, 0, 8'h00, '0, 0, 1, 0);
    chk("t5_ovf_err", VW'(ctx_err), VW'(1));
    chk("t5_ovf_level", VW'(ctx_level), VW'(CD));

    // Underflow, then simultaneous push/pop.
    step(1, 0, 8'h00, '0, 0, 0, 0);
    step(0, 0, 8'h00, '0, 0, 0, 1);
    chk("t5_unf_err", VW'(ctx_err), VW'(1));
    step(1, 0, 8'h00, '0, 0, 0, 0);
    step(0, 0, 8'h00, '0, 0, 1, 1);
    chk("t5_pp_err", VW'(ctx_err), VW'(1));

    // Reset part way through a restore.
    step(1, 0, 8'h00, '0, 0, 0, 0);
    load(8'h05, 8'h5A);
    step(0, 0, 8'h00, '0, 0, 1, 0);
    idle(D);
    load(8'h05, 8'h77);
    step(0, 0, 8'h00, '0, 0, 0, 1);
    idle(5);
    step(1, 0, 8'h00, '0, 0, 0, 0);
    chk("t6_busy", VW'(busy), VW'(0));
    chk("t6_regs", reg_line, '0);
    load(8'h02, 8'h3C);
    chk("t6_load", VW'(reg_line[2*W +: W]), VW'(8'h3C));

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom % 3)
        0:       a = 8'($urandom % D);
        1:       a = 8'h40 | 8'($urandom % 16);
        default: a = 8'($urandom);
      endcase
      step(($urandom % 300) == 0, 1'($urandom), a,
           {$urandom, $urandom, $urandom, $urandom},
           ($urandom % 12) == 0, ($urandom % 20) == 0, ($urandom % 20) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
